// File: rtl/fare_calc.sv
`default_nettype none
// ============================================================================
//  Module   : fare_calc
//  Purpose  : Taxi fare calculator. Takes the 0.1 km distance count from the
//             km counter and produces the fare in 0.1 yuan units. The base
//             fare covers the first FREE_KM. Every further 0.1 km costs RATE.
//             A sequential shift-add multiply computes the distance charge.
//             A sequential double-dabble converter produces the BCD digits.
//             The result saturates at MAX_FARE.
//  Ports    : sys_clk    in   1   system clock, rising edge
//             sys_reset  in   1   synchronous active-high reset
//             data_km    in   16  distance in 0.1 km (async to sys_clk)
//             night      in   1   night tariff select (FARE_NIGHT_EN only)
//             fare_bin   out  16  fare, binary, 0.1 yuan
//             fare_bcd   out  16  fare, 4 BCD digits, [15:12] = hundreds
//             point      out  4   decimal point position, constant 4'b0010
//             fare_valid out  1   one-cycle pulse when the fare updates
//             busy       out  1   high while a computation is in progress
//  Options  : define FARE_NIGHT_EN to add the night port and night tariff
//  Revision : 1.0  initial release
// ============================================================================
module fare_calc #(
    parameter logic [15:0] BASE_FARE  = 16'd100,
    parameter logic [15:0] FREE_KM    = 16'd30,
    parameter logic [3:0]  RATE       = 4'd2,
    parameter logic [3:0]  NIGHT_RATE = 4'd3,
    parameter logic [15:0] MAX_FARE   = 16'd9999
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic [15:0] data_km,
`ifdef FARE_NIGHT_EN
    input  logic        night,
`endif
    output logic [15:0] fare_bin,
    output logic [15:0] fare_bcd,
    output logic [3:0]  point,
    output logic        fare_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_SAT  = 3'd3,
        ST_BCD  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [15:0] C_KM_MAX  = 16'd9999;
    // Reset value of km_last. It never equals a real sample that follows
    // reset, so the first stable sample always starts a computation.
    localparam logic [15:0] C_KM_NONE = 16'hFFFF;
    localparam logic [3:0]  C_MUL_END = 4'd3;
    localparam logic [3:0]  C_BCD_END = 4'd13;

    state_t      state_q, state_d;
    logic [15:0] s1_q, s2_q, s3_q;
    logic [15:0] km_last_q, km_last_d;
    logic [13:0] chg_q, chg_d;
    logic [3:0]  rate_q, rate_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] res_q, res_d;
    // Double-dabble working register: {BCD[15:0], binary[13:0]}.
    logic [29:0] dd_q, dd_d;
    logic [15:0] fare_bin_q, fare_bin_d;
    logic [15:0] fare_bcd_q, fare_bcd_d;

    logic        w_stable;
    logic        w_change;
    logic [15:0] w_km_clamp;
    logic [13:0] w_chg;
    logic [19:0] w_partial;
    logic [19:0] w_sum;
    logic [13:0] w_res;
    logic [29:0] w_dd_step;
    logic [3:0]  w_rate_sel;

`ifdef FARE_NIGHT_EN
    logic n1_q, n2_q;
    logic night_last_q, night_last_d;
`endif

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift.
    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int k = 0; k < 4; k++) begin
            if (t[14+4*k +: 4] >= 4'd5) begin
                t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    assign w_stable   = (s2_q == s3_q);
    assign w_km_clamp = (s3_q > C_KM_MAX) ? C_KM_MAX : s3_q;
    // The clamped distance is at most 9999, so the charge fits in 14 bits.
    assign w_chg      = (w_km_clamp > FREE_KM) ? (w_km_clamp[13:0] - FREE_KM[13:0]) : 14'd0;
    assign w_partial  = {6'd0, chg_q} << cnt_q[1:0];
    assign w_sum      = acc_q + {4'd0, BASE_FARE};
    assign w_res      = (w_sum > {4'd0, MAX_FARE}) ? MAX_FARE[13:0] : w_sum[13:0];
    assign w_dd_step  = dd_step(dd_q);

`ifdef FARE_NIGHT_EN
    assign w_change   = (s3_q != km_last_q) || (n2_q != night_last_q);
    assign w_rate_sel = n2_q ? NIGHT_RATE : RATE;
`else
    assign w_change   = (s3_q != km_last_q);
    assign w_rate_sel = RATE;
`endif

    always_comb begin
        state_d    = state_q;
        km_last_d  = km_last_q;
        chg_d      = chg_q;
        rate_d     = rate_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        dd_d       = dd_q;
        fare_bin_d = fare_bin_q;
        fare_bcd_d = fare_bcd_q;
`ifdef FARE_NIGHT_EN
        night_last_d = night_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_stable && w_change) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                km_last_d = s3_q;
`ifdef FARE_NIGHT_EN
                night_last_d = n2_q;
`endif
                chg_d   = w_chg;
                rate_d  = w_rate_sel;
                acc_d   = 20'd0;
                cnt_d   = 4'd0;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                // Rate bits are consumed LSB first; cnt_q is the bit index.
                if (rate_q[cnt_q[1:0]]) begin
                    acc_d = acc_q + w_partial;
                end
                if (cnt_q == C_MUL_END) begin
                    cnt_d   = 4'd0;
                    state_d = ST_SAT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAT: begin
                res_d   = w_res;
                dd_d    = {16'd0, w_res};
                state_d = ST_BCD;
            end
            ST_BCD: begin
                dd_d = w_dd_step;
                if (cnt_q == C_BCD_END) begin
                    // Last shift: publish so the values are visible in DONE.
                    cnt_d      = 4'd0;
                    fare_bin_d = {2'd0, res_q};
                    fare_bcd_d = w_dd_step[29:14];
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q    <= ST_IDLE;
            s1_q       <= 16'd0;
            s2_q       <= 16'd0;
            s3_q       <= 16'd0;
            km_last_q  <= C_KM_NONE;
            chg_q      <= 14'd0;
            rate_q     <= 4'd0;
            acc_q      <= 20'd0;
            cnt_q      <= 4'd0;
            res_q      <= 14'd0;
            dd_q       <= 30'd0;
            fare_bin_q <= 16'd0;
            fare_bcd_q <= 16'd0;
`ifdef FARE_NIGHT_EN
            n1_q         <= 1'b0;
            n2_q         <= 1'b0;
            night_last_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s1_q       <= data_km;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            km_last_q  <= km_last_d;
            chg_q      <= chg_d;
            rate_q     <= rate_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            dd_q       <= dd_d;
            fare_bin_q <= fare_bin_d;
            fare_bcd_q <= fare_bcd_d;
`ifdef FARE_NIGHT_EN
            n1_q         <= night;
            n2_q         <= n1_q;
            night_last_q <= night_last_d;
`endif
        end
    end

    assign fare_bin   = fare_bin_q;
    assign fare_bcd   = fare_bcd_q;
    assign point      = 4'b0010;
    assign fare_valid = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fare_calc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fare_calc
//  Purpose  : Self-checking bench for fare_calc. It runs a table of distance
//             vectors, hand sequences for the multi-cycle corner cases, and
//             random distances checked against an arithmetic fare model.
//  Options  : define FARE_NIGHT_EN to exercise the night tariff
//  Revision : 1.0  initial release
// ============================================================================
module tb_fare_calc;

    logic        clk = 1'b0;
    logic        sys_reset;
    logic [15:0] data_km;
`ifdef FARE_NIGHT_EN
    logic        night;
`endif
    logic [15:0] fare_bin;
    logic [15:0] fare_bcd;
    logic [3:0]  point;
    logic        fare_valid;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    logic [15:0] prev_bin;

    always #5 clk = ~clk;

    fare_calc dut (
        .sys_clk   (clk),
        .sys_reset (sys_reset),
        .data_km   (data_km),
`ifdef FARE_NIGHT_EN
        .night     (night),
`endif
        .fare_bin  (fare_bin),
        .fare_bcd  (fare_bcd),
        .point     (point),
        .fare_valid(fare_valid),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] km;
        logic [15:0] bin;
        logic [15:0] bcd;
    } vec_t;

    vec_t vecs[13];

    // Fare from the tariff rules with plain integer arithmetic.
    function automatic int model_fare(input int km, input int rate);
        int k, e, f;
        k = (km > 9999) ? 9999 : km;
        e = (k > 30) ? k - 30 : 0;
        f = 100 + e * rate;
        if (f > 9999) f = 9999;
        return f;
    endfunction

    function automatic logic [15:0] to_bcd(input int f);
        return {4'(f / 1000 % 10), 4'(f / 100 % 10), 4'(f / 10 % 10), 4'(f % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Wait for the next fare_valid pulse. busy_cycles counts sampled cycles
    // with busy high up to and including the DONE cycle. held clears if the
    // outputs change before the pulse.
    task automatic wait_fare(input int budget, input logic [15:0] pbin,
                             output bit found, output int busy_cycles,
                             output logic [15:0] b, output logic [15:0] d,
                             output bit held);
        found = 1'b0;
        busy_cycles = 0;
        held = 1'b1;
        b = 16'd0;
        d = 16'd0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (fare_valid) begin
                found = 1'b1;
                b = fare_bin;
                d = fare_bcd;
            end else if (fare_bin !== pbin || fare_bcd !== to_bcd(int'(pbin))) begin
                held = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input string name, input logic [15:0] km,
                           input logic [15:0] eb, input logic [15:0] ed);
        bit found, held;
        int lat;
        logic [15:0] b, d;
        data_km = km;
        wait_fare(200, prev_bin, found, lat, b, d, held);
        check({name, "_found"}, 32'(found), 32'd1);
        check({name, "_bin"}, 32'(b), 32'(eb));
        check({name, "_bcd"}, 32'(d), 32'(ed));
        check({name, "_latency"}, 32'(lat), 32'd21);
        check({name, "_held"}, 32'(held), 32'd1);
        @(negedge clk);
        check({name, "_pulse1"}, 32'(fare_valid), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        prev_bin = eb;
    endtask

    task automatic quiet(input string name, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (fare_valid) cnt++;
        end
        check({name, "_quiet"}, 32'(cnt), 32'd0);
    endtask

    task automatic wait_busy(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check({name, "_busy_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, held;
        int lat, cnt, r, prev_km;
        logic [15:0] b, d;

        vecs[0]  = '{16'd30,    16'd100,  16'h0100};
        vecs[1]  = '{16'd31,    16'd102,  16'h0102};
        vecs[2]  = '{16'd125,   16'd290,  16'h0290};
        vecs[3]  = '{16'd9999,  16'd9999, 16'h9999};
        vecs[4]  = '{16'd10000, 16'd9999, 16'h9999};
        vecs[5]  = '{16'd12345, 16'd9999, 16'h9999};
        vecs[6]  = '{16'd4979,  16'd9998, 16'h9998};
        vecs[7]  = '{16'd4980,  16'd9999, 16'h9999};
        vecs[8]  = '{16'd4964,  16'd9968, 16'h9968};
        vecs[9]  = '{16'd35,    16'd110,  16'h0110};
        vecs[10] = '{16'd29,    16'd100,  16'h0100};
        vecs[11] = '{16'd1,     16'd100,  16'h0100};
        vecs[12] = '{16'd0,     16'd100,  16'h0100};

        sys_reset = 1'b1;
        data_km   = 16'd0;
`ifdef FARE_NIGHT_EN
        night     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_bin", 32'(fare_bin), 32'd0);
        check("rst_bcd", 32'(fare_bcd), 32'd0);
        check("rst_valid", 32'(fare_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("point", 32'(point), 32'h2);
        sys_reset = 1'b0;

        // First stable sample after reset computes exactly once.
        cnt = 0;
        b = 16'd0;
        d = 16'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fare_valid) begin
                cnt++;
                b = fare_bin;
                d = fare_bcd;
            end
        end
        check("init_count", 32'(cnt), 32'd1);
        check("init_bin", 32'(b), 32'd100);
        check("init_bcd", 32'(d), 32'h0100);
        check("init_busy", 32'(busy), 32'd0);
        prev_bin = 16'd100;

        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d_km%0d", i, vecs[i].km), vecs[i].km, vecs[i].bin, vecs[i].bcd);
            quiet($sformatf("vec%0d", i), 100);
        end

        // Distance changes during BCD: first result finishes, then a recompute.
        data_km = 16'd50;
        wait_busy("chg50");
        repeat (9) @(negedge clk);
        data_km = 16'd60;
        wait_fare(100, prev_bin, found, lat, b, d, held);
        check("chg_first_found", 32'(found), 32'd1);
        check("chg_first_bin", 32'(b), 32'd140);
        check("chg_first_bcd", 32'(d), 32'h0140);
        @(negedge clk);
        check("chg_gap_idle", 32'(busy), 32'd0);
        wait_fare(100, 16'd140, found, lat, b, d, held);
        check("chg_second_found", 32'(found), 32'd1);
        check("chg_second_bin", 32'(b), 32'd160);
        check("chg_second_bcd", 32'(d), 32'h0160);
        check("chg_second_latency", 32'(lat), 32'd21);
        check("chg_second_held", 32'(held), 32'd1);
        prev_bin = 16'd160;
        quiet("chg", 60);

        // Reset during MUL, then recompute of the current distance.
        data_km = 16'd80;
        wait_busy("rst80");
        repeat (2) @(negedge clk);
        sys_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_bin", 32'(fare_bin), 32'd0);
        check("midrst_bcd", 32'(fare_bcd), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(fare_valid), 32'd0);
        sys_reset = 1'b0;
        found = 1'b0;
        d = 16'd0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (fare_valid && fare_bin == 16'd200) begin
                found = 1'b1;
                d = fare_bcd;
            end
        end
        check("midrst_recompute", 32'(found), 32'd1);
        check("midrst_recompute_bcd", 32'(d), 32'h0200);
        prev_bin = 16'd200;
        quiet("midrst", 60);
        prev_km = 80;

`ifdef FARE_NIGHT_EN
        night = 1'b1;
        run_vec("night_on", 16'd40, 16'd130, 16'h0130);
        night = 1'b0;
        run_vec("night_off", 16'd40, 16'd120, 16'h0120);
        prev_km = 40;
`endif

        for (int i = 0; i < 40; i++) begin
            r = prev_km;
            for (int t = 0; t < 20 && r == prev_km; t++) begin
                r = int'($urandom_range(0, 12000));
            end
            if (r == prev_km) r = (prev_km == 0) ? 1 : 0;
            run_vec($sformatf("rnd%0d_km%0d", i, r), 16'(r),
                    16'(model_fare(r, 2)), to_bcd(model_fare(r, 2)));
            prev_km = r;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
